// File: rtl/barrett_mod_acc.sv
// Fully reduces partially-reduced Barrett terms (range [0,3q)) and accumulates a modular sum.
// Optional input range checking (t_in >= 3q sets sticky err) is enabled by BARRETT_RANGE_CHK_EN.
module barrett_mod_acc #(
    parameter int W     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [W-1:0]     q,
    input  logic [W-1:0]     t_in,
    input  logic             t_valid,
    output logic             t_ready,
    output logic [W-1:0]     acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     q_reg;
    logic [CNT_W-1:0] len_reg;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     r_p1;
    logic             vld_p1;
    logic             vld_p2;
    logic [W-1:0]     acc;
    logic             accept;
    logic             start_ok;
    logic             last_beat;

    // Conditional subtractions bring a term from [0,3q) into [0,q).
    function automatic logic [W-1:0] reduce_term(input logic [W-1:0] t, input logic [W-1:0] m);
        logic [W-1:0] r;
        r = t;
        if (r >= m) r = r - m;
        if (r >= m) r = r - m;
`ifdef BARRETT_RANGE_CHK_EN
        if (r >= m) r = r - m;
`endif
        return r;
    endfunction

    // Sum of two residues is below 2q, so one subtraction at W+1 bits suffices.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

`ifdef BARRETT_RANGE_CHK_EN
    logic err_flag;

    function automatic logic over_range(input logic [W-1:0] t, input logic [W-1:0] m);
        logic [W+1:0] m3;
        m3 = {2'b00, m} + {1'b0, m, 1'b0};
        return ({2'b00, t} >= m3);
    endfunction

    assign err = err_flag;
`else
    assign err = 1'b0;
`endif

    assign t_ready   = (state == ACC) && (cnt < len_reg);
    assign accept    = t_valid && t_ready;
    assign start_ok  = start && (state == IDLE);
    assign last_beat = accept && (cnt == len_reg - 1'b1);
    assign busy      = (state != IDLE);
    assign acc_valid = (state == DONE);
    assign acc_out   = acc_valid ? acc : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACC;
            ACC:     if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (!vld_p1 && !vld_p2) state_nxt = DONE;
            DONE:    if (acc_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q_reg   <= '0;
            len_reg <= '0;
            cnt     <= '0;
            r_p1    <= '0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            acc     <= '0;
`ifdef BARRETT_RANGE_CHK_EN
            err_flag <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
            if (start_ok) begin
                q_reg   <= q;
                len_reg <= len;
                cnt     <= '0;
                acc     <= '0;
`ifdef BARRETT_RANGE_CHK_EN
                err_flag <= 1'b0;
`endif
            end else begin
                // stage 1: reduce accepted term
                if (accept) begin
                    cnt  <= cnt + 1'b1;
                    r_p1 <= reduce_term(t_in, q_reg);
`ifdef BARRETT_RANGE_CHK_EN
                    if (over_range(t_in, q_reg)) err_flag <= 1'b1;
`endif
                end
                // stage 2: modular accumulate
                if (vld_p1) acc <= mod_add(acc, r_p1, q_reg);
            end
        end
    end

endmodule

// File: tb/tb_barrett_mod_acc.sv
// Self-checking bench for barrett_mod_acc: directed and random jobs against a modular-sum model.
module tb_barrett_mod_acc;
    localparam int W     = 64;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, start, t_valid, acc_ready;
    logic             t_ready, acc_valid, busy, err;
    logic [CNT_W-1:0] len;
    logic [W-1:0]     q, t_in, acc_out;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] terms [0:63];

    always #5 clk = ~clk;

    barrett_mod_acc #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .q(q),
        .t_in(t_in), .t_valid(t_valid), .t_ready(t_ready),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .busy(busy), .err(err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sum of (t mod q), reduced mod q after each addition.
    function automatic logic [W-1:0] model_sum(input logic [W-1:0] qv, input int n);
        logic [W:0] s;
        s = '0;
        for (int i = 0; i < n; i++)
            s = ({1'b0, s[W-1:0]} + {1'b0, terms[i] % qv}) % {1'b0, qv};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_term(input logic [W-1:0] qv);
        logic [W+1:0] v;
        logic [W-1:0] base;
        base = {$urandom, $urandom} % qv;
        v = {2'b00, base} + {2'b00, qv} * 66'($urandom_range(0, 2));
        return (v[W+1:W] != 2'b00) ? base : v[W-1:0];
    endfunction

    // mode 0: t_valid always high, 1: random gaps, 2: fixed 1,0,0,1,1,0,1 pattern
    task automatic run_job(input logic [W-1:0] qv, input int n, input int mode,
                           input int hold, input string tag);
        logic [W-1:0] expv;
        logic [6:0]   pat;
        int idx, cyc, k, p;
        bit a;
        pat  = 7'b1011001;
        expv = model_sum(qv, n);
        q = qv; len = CNT_W'(n); start = 1'b1;
        tick();
        start = 1'b0; q = '0; len = '0;
        if (n == 0) check($sformatf("%s.t_ready_len0", tag), W'(t_ready), W'(0));
        idx = 0; cyc = 0; p = 0;
        while (idx < n && cyc < 2000) begin
            case (mode)
                0:       t_valid = 1'b1;
                1:       t_valid = 1'($urandom_range(0, 1));
                default: t_valid = (p < 7) ? pat[p] : 1'b1;
            endcase
            t_in = terms[idx];
            a = t_valid && t_ready;
            tick();
            if (a) idx++;
            p++;
            cyc++;
        end
        check($sformatf("%s.beats", tag), W'(idx), W'(n));
        t_valid = 1'b1;
        t_in = 64'd5;
        k = 0;
        while (!acc_valid && k < 20) begin
            tick();
            k++;
        end
        t_valid = 1'b0;
        if (n != 0) check($sformatf("%s.latency", tag), W'(k), W'(3));
        check($sformatf("%s.t_ready_done", tag), W'(t_ready), W'(0));
        check($sformatf("%s.acc_valid", tag), W'(acc_valid), W'(1));
        check($sformatf("%s.acc_out", tag), acc_out, expv);
        check($sformatf("%s.busy", tag), W'(busy), W'(1));
        for (int h = 0; h < hold; h++) begin
            tick();
            check($sformatf("%s.hold_out", tag), acc_out, expv);
            check($sformatf("%s.hold_valid", tag), W'(acc_valid), W'(1));
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check($sformatf("%s.valid_after", tag), W'(acc_valid), W'(0));
        check($sformatf("%s.busy_after", tag), W'(busy), W'(0));
    endtask

    initial begin
        logic [W-1:0] qv;
        int n;
        rst = 1'b1; start = 1'b0; t_valid = 1'b0; acc_ready = 1'b0;
        len = '0; q = '0; t_in = '0;
        tick();
        tick();
        check("rst.t_ready", W'(t_ready), W'(0));
        check("rst.acc_out", acc_out, W'(0));
        check("rst.acc_valid", W'(acc_valid), W'(0));
        check("rst.busy", W'(busy), W'(0));
        check("rst.err", W'(err), W'(0));
        rst = 1'b0;
        tick();

        terms[0] = 64'd5; terms[1] = 64'd20; terms[2] = 64'd30;
        run_job(64'd17, 3, 0, 1, "basic");
        check("basic.err", W'(err), W'(0));

        run_job(64'd17, 0, 0, 1, "len0");

        qv = 64'hFFFF_FFFF_FFFF_FFC5;
        terms[0] = qv - 1; terms[1] = qv - 1;
        run_job(qv, 2, 0, 1, "bigq");

        terms[0] = 64'd16; terms[1] = 64'd33; terms[2] = 64'd2; terms[3] = 64'd50;
        run_job(64'd17, 4, 2, 5, "gaps");

`ifdef BARRETT_RANGE_CHK_EN
        terms[0] = 64'd60; terms[1] = 64'd1;
        run_job(64'd17, 2, 0, 1, "range");
        check("range.err_set", W'(err), W'(1));
        q = 64'd17; len = '0; start = 1'b1;
        tick();
        start = 1'b0;
        check("range.err_clear", W'(err), W'(0));
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
`endif

        // Reset in the middle of a five-term job, after two accepted beats
        q = 64'd17; len = CNT_W'(5); start = 1'b1;
        tick();
        start = 1'b0;
        t_valid = 1'b1; t_in = 64'd9;
        tick();
        tick();
        t_valid = 1'b0; rst = 1'b1;
        tick();
        check("midrst.t_ready", W'(t_ready), W'(0));
        check("midrst.acc_out", acc_out, W'(0));
        check("midrst.acc_valid", W'(acc_valid), W'(0));
        check("midrst.busy", W'(busy), W'(0));
        check("midrst.err", W'(err), W'(0));
        rst = 1'b0;
        tick();
        terms[0] = 64'd3;
        run_job(64'd17, 1, 0, 1, "post_rst");

        for (int j = 0; j < 8; j++) begin
            if (j % 2 == 0) qv = W'($urandom_range(2, 1000));
            else            qv = {$urandom, $urandom} | 64'h2;
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) terms[i] = rand_term(qv);
            run_job(qv, n, 1, 2, $sformatf("rand%0d", j));
            check($sformatf("rand%0d.err", j), W'(err), W'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
